// File: rtl/emergency_req_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : emergency_req_ctrl                                           |
// | Description : Debounced emergency-request controller. Synchronizes and     |
// |               debounces a raw button and drives an override level for the  |
// |               traffic-light FSM with a minimum hold and a cooldown window.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module emergency_req_ctrl #(
  parameter int TICK_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int HOLD_TICKS     = 10000,
  parameter int COOLDOWN_TICKS = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       emg_btn,
  input  logic       emg_clear,
  output logic       emergency,
  output logic       cooldown,
  output logic       dropped,
  output logic [7:0] req_count
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int COOL_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  // Synchronizer, timing and debounce state
  logic              sync1_q, sync2_q;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              clean_q, clean_d;
  logic              clean_prev_q;
  logic              rise;

  // Controller state
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [COOL_W-1:0] cd_q, cd_d;
  logic [7:0]        req_count_q, req_count_d;
  logic              emergency_q, emergency_d;
  logic              cooldown_q, cooldown_d;
  logic              dropped_q, dropped_d;

  // Free-running tick divider: one-cycle tick on the last count
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Debounce: a new level must persist DEBOUNCE_TICKS ticks; any return to
  // the accepted level restarts the count so short glitches are discarded
  always_comb begin
    clean_d   = clean_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q == clean_q) begin
      deb_cnt_d = '0;
    end else if (tick) begin
      if (deb_cnt_q == DEB_LAST) begin
        clean_d   = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Request event is the rising edge of the debounced level only
  assign rise = clean_q & ~clean_prev_q;

  // Controller next state: IDLE -> ACTIVE -> COOLDOWN -> IDLE
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cd_d        = cd_q;
    req_count_d = req_count_q;
    dropped_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_ACTIVE;
          hold_d  = '0;
          if (req_count_q != 8'hFF) begin
            req_count_d = req_count_q + 8'd1;
          end
        end
      end
      ST_ACTIVE: begin
        // Clear and hold expiry share one exit so coincidence has no extra effect;
        // requests arriving here are absorbed
        if (emg_clear || ((hold_q == HOLD_MAX) && !clean_q)) begin
          state_d = ST_COOLDOWN;
          cd_d    = '0;
        end else if (tick && (hold_q != HOLD_MAX)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_COOLDOWN: begin
        // A request here is rejected even on the cycle the window closes
        dropped_d = rise;
        if (tick) begin
          if (cd_q == COOL_LAST) begin
            state_d = ST_IDLE;
            cd_d    = '0;
          end else begin
            cd_d = cd_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    emergency_d = (state_d == ST_ACTIVE);
    cooldown_d  = (state_d == ST_COOLDOWN);
  end

  // All state registers; reset dominates every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      tick_cnt_q   <= '0;
      deb_cnt_q    <= '0;
      clean_q      <= 1'b0;
      clean_prev_q <= 1'b0;
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      cd_q         <= '0;
      req_count_q  <= 8'd0;
      emergency_q  <= 1'b0;
      cooldown_q   <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      sync1_q      <= emg_btn;
      sync2_q      <= sync1_q;
      tick_cnt_q   <= tick_cnt_d;
      deb_cnt_q    <= deb_cnt_d;
      clean_q      <= clean_d;
      clean_prev_q <= clean_q;
      state_q      <= state_d;
      hold_q       <= hold_d;
      cd_q         <= cd_d;
      req_count_q  <= req_count_d;
      emergency_q  <= emergency_d;
      cooldown_q   <= cooldown_d;
      dropped_q    <= dropped_d;
    end
  end

  assign emergency = emergency_q;
  assign cooldown  = cooldown_q;
  assign dropped   = dropped_q;
  assign req_count = req_count_q;

endmodule
`default_nettype wire

// File: tb/tb_emergency_req_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_emergency_req_ctrl                                        |
// | Description : Self-checking bench for emergency_req_ctrl against a         |
// |               behavioural reference model, directed plus random stimulus.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_emergency_req_ctrl;

  localparam int TDIV  = 4;
  localparam int DEB   = 3;
  localparam int HOLD  = 5;
  localparam int COOLT = 4;

  localparam int M_IDLE = 0;
  localparam int M_ACT  = 1;
  localparam int M_COOL = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       emg_btn = 1'b0;
  logic       emg_clear = 1'b0;
  logic       emergency;
  logic       cooldown;
  logic       dropped;
  logic [7:0] req_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_phase;
  bit m_s1, m_s2, m_clean, m_prev;
  int m_mis;
  int m_mode;
  int m_hold, m_cd, m_cnt;
  bit m_emg, m_cool, m_drop;

  emergency_req_ctrl #(
    .TICK_DIV       (TDIV),
    .DEBOUNCE_TICKS (DEB),
    .HOLD_TICKS     (HOLD),
    .COOLDOWN_TICKS (COOLT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .emg_btn   (emg_btn),
    .emg_clear (emg_clear),
    .emergency (emergency),
    .cooldown  (cooldown),
    .dropped   (dropped),
    .req_count (req_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the specification's behaviour, written in terms of elapsed
  // ticks and mismatch durations
  task automatic model_clk(input bit btn, input bit clr, input bit rst);
    bit tk;
    bit rise;
    bit nclean;
    int nmis;
    int nmode;
    if (rst) begin
      m_phase = 0; m_s1 = 0; m_s2 = 0; m_clean = 0; m_prev = 0; m_mis = 0;
      m_mode = M_IDLE; m_hold = 0; m_cd = 0; m_cnt = 0; m_drop = 0;
      nmode = M_IDLE;
    end else begin
      tk = ((m_phase % TDIV) == TDIV - 1);
      m_phase++;
      rise = m_clean && !m_prev;
      nclean = m_clean;
      nmis = m_mis;
      if (m_s2 == m_clean) nmis = 0;
      else if (tk) begin
        if (m_mis + 1 == DEB) begin
          nclean = m_s2;
          nmis = 0;
        end else nmis = m_mis + 1;
      end
      m_drop = 0;
      nmode = m_mode;
      if (m_mode == M_IDLE) begin
        if (rise) begin
          nmode = M_ACT;
          m_hold = 0;
          if (m_cnt < 255) m_cnt++;
        end
      end else if (m_mode == M_ACT) begin
        if (clr || (m_hold >= HOLD && !m_clean)) begin
          nmode = M_COOL;
          m_cd = 0;
        end else if (tk && m_hold < HOLD) m_hold++;
      end else begin
        m_drop = rise;
        if (tk) begin
          if (m_cd + 1 == COOLT) nmode = M_IDLE;
          else m_cd++;
        end
      end
      m_prev = m_clean;
      m_clean = nclean;
      m_mis = nmis;
      m_s2 = m_s1;
      m_s1 = btn;
      m_mode = nmode;
    end
    m_emg  = (nmode == M_ACT);
    m_cool = (nmode == M_COOL);
  endtask

  // Drive one cycle, advance the model with the same inputs, compare outputs
  task automatic step(input bit btn, input bit clr, input bit rst);
    @(negedge clk);
    emg_btn = btn;
    emg_clear = clr;
    reset = rst;
    @(posedge clk);
    model_clk(btn, clr, rst);
    #1;
    check("emergency", int'(emergency), int'(m_emg));
    check("cooldown", int'(cooldown), int'(m_cool));
    check("dropped", int'(dropped), int'(m_drop));
    check("req_count", int'(req_count), m_cnt);
  endtask

  task automatic wait_emergency(input int budget);
    for (int i = 0; i < budget && emergency !== 1'b1; i++) step(1'b1, 1'b0, 1'b0);
    check("wait_emergency", int'(emergency), 1);
  endtask

  initial begin
    // Reset state
    step(0, 0, 1);
    step(0, 0, 1);
    check("rst_emergency", int'(emergency), 0);
    check("rst_cooldown", int'(cooldown), 0);
    check("rst_dropped", int'(dropped), 0);
    check("rst_req_count", int'(req_count), 0);

    // Clean 100-cycle press, then release and let the cycle complete
    for (int i = 0; i < 100; i++) step(1, 0, 0);
    check("press_count", int'(req_count), 1);
    check("press_emergency", int'(emergency), 1);
    for (int i = 0; i < 70; i++) step(0, 0, 0);
    check("press_back_idle", int'(emergency | cooldown), 0);

    // Glitch shorter than the debounce window
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 0);
    check("glitch_emergency", int'(emergency), 0);
    check("glitch_count", int'(req_count), 1);

    // Operator clear two ticks into ACTIVE
    wait_emergency(60);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    step(1, 1, 0);
    check("clear_emergency", int'(emergency), 0);
    check("clear_cooldown", int'(cooldown), 1);
    for (int i = 0; i < 60; i++) step(0, 0, 0);

    // Re-press attempts around the cooldown window with varying gaps
    for (int g = 0; g < 8; g++) begin
      wait_emergency(60);
      step(0, 1, 0);
      for (int i = 0; i < g; i++) step(0, 0, 0);
      for (int i = 0; i < 40; i++) step(1, 0, 0);
      for (int i = 0; i < 60; i++) step(0, 0, 0);
    end

    // Randomized segments of button level with sporadic clears and resets
    for (int s = 0; s < 150; s++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 45);
      for (int i = 0; i < len; i++)
        step(lvl, ($urandom_range(0, 15) == 0), ($urandom_range(0, 399) == 0));
    end
    for (int i = 0; i < 60; i++) step(0, 0, 0);

    // Reset in the middle of ACTIVE
    wait_emergency(60);
    step(0, 0, 1);
    check("midrst_emergency", int'(emergency), 0);
    check("midrst_count", int'(req_count), 0);
    for (int i = 0; i < 30; i++) step(0, 0, 0);

    // 256 accepted requests saturate the counter
    for (int r = 0; r < 256; r++) begin
      wait_emergency(60);
      step(0, 1, 0);
      for (int i = 0; i < 32; i++) step(0, 0, 0);
    end
    check("sat_count", int'(req_count), 255);
    wait_emergency(60);
    check("sat_hold", int'(req_count), 255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
